// File: rtl/cp0_exc_unit_pkg.sv
// CP0 exception unit shared definitions: register numbers, ExcCodes,
// field positions and exc_i bit indices.
package cp0_exc_unit_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int EI_ADEL_IF = 7;
  localparam int EI_RI      = 6;
  localparam int EI_OV      = 5;
  localparam int EI_BP      = 4;
  localparam int EI_SYS     = 3;
  localparam int EI_ADEL_D  = 2;
  localparam int EI_ADES    = 1;
  localparam int EI_ERET    = 0;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_IM  = 8;

  localparam int CA_TI  = 30;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    exc_code_e code;
    logic      ld_badv;
    logic      badv_pc;
  } exc_dec_t;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// MFC0/MTC0 register access bus between the pipeline and CP0.
interface cp0_exc_unit_if;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    input  rd_data_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    output rd_data_o
  );
endinterface

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer with prescaler and sticky timer interrupt flag.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam logic [1:0] PRE_MAX = 2'(COUNT_DIV - 1);

  logic [1:0]  pre_q, pre_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  always_comb begin
    tick      = (pre_q == PRE_MAX);
    pre_d     = tick ? 2'd0 : pre_q + 2'd1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wr_data_i;
      pre_d   = 2'd0;
    end
    if (compare_we_i) begin
      compare_d = wr_data_i;
    end
    // A Compare write always wins: it is the only way to clear TI.
    if (compare_we_i) begin
      ti_d = 1'b0;
    end else if ((tick || count_we_i) && count_d == compare_q
                 && compare_q != '0) begin
      ti_d = 1'b1;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: Status/Cause/EPC/BadVAddr, timer,
// commit-time exception arbitration and registered flush redirect.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_exc_unit_if.slave         bus,
  input  logic                  commit_i,
  input  logic [7:0]            exc_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           bad_addr_i,
  input  logic                  in_ds_i,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o,
  output logic                  timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  exc_code_e   code_q, code_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  hw_q, hw_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  logic [31:0] count, compare, cause;
  logic        ti;
  logic [7:0]  ip;
  logic        pending, active, take, eret;
  logic        wr_ok;
  logic [31:0] epc_fwd;
  exc_dec_t    dec;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_ok && bus.wr_addr_i == REG_COUNT),
    .compare_we_i (wr_ok && bus.wr_addr_i == REG_COMPARE),
    .wr_data_i    (bus.wr_data_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // The sixth hardware line shares IP7 with the timer.
  assign hw_d  = 6'(hw_int_i);
  assign ip    = {hw_q[5] | ti, hw_q[4:0], ip_sw_q};
  assign cause = {bd_q, ti, 14'b0, ip, 1'b0, code_q, 2'b0};

  assign pending = status_q[ST_IE] & ~status_q[ST_EXL]
                 & |(ip & status_q[ST_IM+:8]);
  assign active  = commit_i & ~flush_q;
  assign take    = active & (pending | |exc_i[7:1]);
  assign eret    = active & ~take & exc_i[EI_ERET];
  assign wr_ok   = bus.wr_en_i & ~take;

  always_comb begin
    dec      = '0;
    dec.code = EXC_INT;
    priority case (1'b1)
      pending: dec.code = EXC_INT;
      exc_i[EI_ADEL_IF]: begin
        dec.code    = EXC_ADEL;
        dec.ld_badv = 1'b1;
        dec.badv_pc = 1'b1;
      end
      exc_i[EI_RI]:  dec.code = EXC_RI;
      exc_i[EI_OV]:  dec.code = EXC_OV;
      exc_i[EI_BP]:  dec.code = EXC_BP;
      exc_i[EI_SYS]: dec.code = EXC_SYS;
      exc_i[EI_ADEL_D]: begin
        dec.code    = EXC_ADEL;
        dec.ld_badv = 1'b1;
      end
      exc_i[EI_ADES]: begin
        dec.code    = EXC_ADES;
        dec.ld_badv = 1'b1;
      end
      default: ;
    endcase
  end

  assign epc_fwd = (wr_ok && bus.wr_addr_i == REG_EPC)
                 ? bus.wr_data_i : epc_q;

  always_comb begin
    status_d = status_q;
    epc_d    = epc_q;
    badv_d   = badv_q;
    code_d   = code_q;
    bd_d     = bd_q;
    ip_sw_d  = ip_sw_q;
    if (wr_ok) begin
      unique case (bus.wr_addr_i)
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK)
                             | (bus.wr_data_i & STATUS_WMASK);
        REG_CAUSE:  ip_sw_d  = bus.wr_data_i[9:8];
        REG_EPC:    epc_d    = bus.wr_data_i;
        default: ;
      endcase
    end
    if (take) begin
      code_d = dec.code;
      if (dec.ld_badv) begin
        badv_d = dec.badv_pc ? pc_i : bad_addr_i;
      end
      // A nested exception keeps the original return point.
      if (!status_q[ST_EXL]) begin
        epc_d = in_ds_i ? pc_i - 32'd4 : pc_i;
        bd_d  = in_ds_i;
      end
      status_d[ST_EXL] = 1'b1;
    end else if (eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  always_comb begin
    flush_d    = take | eret;
    flush_pc_d = '0;
    if (eret) begin
      flush_pc_d = epc_fwd;
    end else if (take) begin
      flush_pc_d = EXC_VECTOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badv_q     <= '0;
      code_q     <= EXC_INT;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      hw_q       <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badv_q     <= badv_d;
      code_q     <= code_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      hw_q       <= hw_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  logic [31:0] rd_cur, rd_mask;

  always_comb begin
    rd_cur  = '0;
    rd_mask = '0;
    unique case (bus.rd_addr_i)
      REG_BADVADDR: rd_cur = badv_q;
      REG_COUNT: begin
        rd_cur  = count;
        rd_mask = '1;
      end
      REG_COMPARE: begin
        rd_cur  = compare;
        rd_mask = '1;
      end
      REG_STATUS: begin
        rd_cur  = status_q;
        rd_mask = STATUS_WMASK;
      end
      REG_CAUSE: begin
        rd_cur  = cause;
        rd_mask = CAUSE_WMASK;
      end
      REG_EPC: begin
        rd_cur  = epc_q;
        rd_mask = '1;
      end
      default: ;
    endcase
    if (bus.wr_en_i && bus.wr_addr_i == bus.rd_addr_i) begin
      bus.rd_data_o = (rd_cur & ~rd_mask) | (bus.wr_data_i & rd_mask);
    end else begin
      bus.rd_data_o = rd_cur;
    end
  end

  assign flush_o     = flush_q;
  assign flush_pc_o  = flush_pc_q;
  assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed scoreboard bench for cp0_exc_unit.
module tb_cp0_exc_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_i;
  logic [7:0]  exc_i;
  logic [31:0] pc_i;
  logic [31:0] bad_addr_i;
  logic        in_ds_i;
  logic [5:0]  hw_int_i;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic        timer_int_o;

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(
    .NUM_HW_INT (6),
    .COUNT_DIV  (2),
    .EXC_VECTOR (VEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .commit_i    (commit_i),
    .exc_i       (exc_i),
    .pc_i        (pc_i),
    .bad_addr_i  (bad_addr_i),
    .in_ds_i     (in_ds_i),
    .hw_int_i    (hw_int_i),
    .flush_o     (flush_o),
    .flush_pc_o  (flush_pc_o),
    .timer_int_o (timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miss = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    vecs++;
    if (sb.size() == 0) begin
      miss++;
      $error("FAIL sb_empty observed=%h required=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miss++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a,
                         input logic [31:0] v);
    push(tag, v);
    bus.rd_addr_i = a;
    #1;
    pop_chk(bus.rd_data_o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_i       = 1'b0;
    exc_i          = '0;
    in_ds_i        = 1'b0;
    bus.wr_en_i    = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = a;
    bus.wr_data_i = d;
    tick();
    bus.wr_en_i   = 1'b0;
  endtask

  task automatic commit(input logic [7:0] e, input logic [31:0] pc,
                        input logic ds);
    commit_i = 1'b1;
    exc_i    = e;
    pc_i     = pc;
    in_ds_i  = ds;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    hw_int_i      = '0;
    pc_i          = '0;
    bad_addr_i    = '0;
    bus.rd_addr_i = '0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    idle();
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    push("rst_flush", 32'd0);
    push("rst_ti", 32'd0);
    pop_chk(32'(flush_o));
    pop_chk(32'(timer_int_o));
    chk_reg("rst_status", 5'd12, 32'h0040_0000);
    chk_reg("rst_cause", 5'd13, 32'h0);
    chk_reg("rst_epc", 5'd14, 32'h0);
    chk_reg("rst_count", 5'd9, 32'h0);

    // unimplemented register and read-only BadVAddr
    mtc0(5'd5, 32'hFFFF_FFFF);
    chk_reg("unimpl", 5'd5, 32'h0);
    mtc0(5'd8, 32'h1234_5678);
    chk_reg("badv_ro", 5'd8, 32'h0);

    // same-cycle write forwarding honours the Status mask
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 5'd12;
    bus.wr_data_i = 32'hFFFF_FFFC;
    chk_reg("fwd_status", 5'd12, 32'h0040_FF00);
    tick();
    bus.wr_en_i = 1'b0;
    chk_reg("wr_status", 5'd12, 32'h0040_FF00);

    // timer: Compare=10, Count=0, DIV=2 -> TI after 20 clocks
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    push("ti_clocks", 32'd20);
    n = 0;
    while (!timer_int_o && n < 40) begin
      tick();
      n++;
    end
    pop_chk(32'(n));
    chk_reg("ti_count", 5'd9, 32'd10);
    chk_reg("ti_cause", 5'd13, 32'h4000_8000);
    mtc0(5'd11, 32'd0);
    push("ti_clr", 32'd0);
    pop_chk(32'(timer_int_o));
    chk_reg("ti_clr_cause", 5'd13, 32'h0);

    // hardware interrupt
    mtc0(5'd12, 32'h0000_0401);
    hw_int_i = 6'b000001;
    tick();
    commit(8'h00, 32'h100, 1'b0);
    push("int_flush", 32'd1);
    push("int_pc", VEC);
    tick();
    idle();
    hw_int_i = '0;
    pop_chk(32'(flush_o));
    pop_chk(flush_pc_o);
    chk_reg("int_epc", 5'd14, 32'h100);
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    chk_reg("int_status", 5'd12, 32'h0040_0403);
    push("int_pulse", 32'd0);
    tick();
    pop_chk(32'(flush_o));

    // RI+OV in a delay slot
    mtc0(5'd12, 32'h0);
    commit(8'h60, 32'h204, 1'b1);
    push("ri_flush", 32'd1);
    tick();
    idle();
    pop_chk(32'(flush_o));
    chk_reg("ri_epc", 5'd14, 32'h200);
    chk_reg("ri_cause", 5'd13, 32'h8000_0028);

    // commit during the flush cycle is ignored
    commit(8'h08, 32'h400, 1'b0);
    push("ign_flush", 32'd0);
    tick();
    idle();
    pop_chk(32'(flush_o));
    chk_reg("ign_cause", 5'd13, 32'h8000_0028);

    // nested ADES while EXL=1
    bad_addr_i = 32'hDEAD_0000;
    commit(8'h02, 32'h500, 1'b0);
    push("nest_flush", 32'd1);
    tick();
    idle();
    pop_chk(32'(flush_o));
    chk_reg("nest_epc", 5'd14, 32'h200);
    chk_reg("nest_cause", 5'd13, 32'h8000_0014);
    chk_reg("nest_badv", 5'd8, 32'hDEAD_0000);
    tick();

    // ERET to EPC
    mtc0(5'd14, 32'h300);
    commit(8'h01, 32'h600, 1'b0);
    push("eret_flush", 32'd1);
    push("eret_pc", 32'h300);
    tick();
    idle();
    pop_chk(32'(flush_o));
    pop_chk(flush_pc_o);
    chk_reg("eret_status", 5'd12, 32'h0040_0000);
    tick();

    // ERET with same-cycle MTC0 EPC
    commit(8'h01, 32'h600, 1'b0);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 5'd14;
    bus.wr_data_i = 32'h400;
    push("eret_fwd_pc", 32'h400);
    tick();
    idle();
    pop_chk(flush_pc_o);
    chk_reg("eret_fwd_epc", 5'd14, 32'h400);
    tick();

    // MTC0 suppressed by a taken BP
    commit(8'h10, 32'h600, 1'b0);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 5'd12;
    bus.wr_data_i = 32'h1;
    push("bp_pc", VEC);
    tick();
    idle();
    pop_chk(flush_pc_o);
    chk_reg("bp_status", 5'd12, 32'h0040_0002);
    chk_reg("bp_cause", 5'd13, 32'h0000_0024);
    chk_reg("bp_epc", 5'd14, 32'h600);
    tick();

    // reset during the flush cycle
    commit(8'h08, 32'h700, 1'b0);
    push("mid_flush", 32'd1);
    tick();
    idle();
    pop_chk(32'(flush_o));
    rst = 1'b1;
    #1;
    push("mid_rst_flush", 32'd0);
    push("mid_rst_pc", 32'd0);
    pop_chk(32'(flush_o));
    pop_chk(flush_pc_o);
    chk_reg("mid_rst_status", 5'd12, 32'h0040_0000);
    tick();
    rst = 1'b0;
    push("post_rst_flush", 32'd0);
    tick();
    pop_chk(32'(flush_o));

    // ADEL on fetch loads BadVAddr from the PC
    commit(8'h80, 32'h0000_BAD0, 1'b0);
    push("adelif_flush", 32'd1);
    tick();
    idle();
    pop_chk(32'(flush_o));
    chk_reg("adelif_badv", 5'd8, 32'h0000_BAD0);
    chk_reg("adelif_epc", 5'd14, 32'h0000_BAD0);
    chk_reg("adelif_cause", 5'd13, 32'h0000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
